fft_butterfly_pipe: RTL and testbench

FFT_BUTTERFLY_PIPE -- requirements
Module: fft_butterfly_pipe

---
 rtl/fft_butterfly_pipe.sv | 149 ++++++++++++++
 tb/tb_fft_butterfly_pipe.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/fft_butterfly_pipe.sv
// rtl/fft_butterfly_pipe.sv - radix-2 DIT butterfly, 3-stage pipeline with global stall
module fft_butterfly_pipe #(
    parameter int WIDTH     = 16,
    parameter int TW_WIDTH  = 16,
    parameter int TW_FRAC   = 14,
    parameter int TAG_WIDTH = 8
) (
    input  logic                 clk_i,
    input  logic                 rst_n_i,
    input  logic                 in_valid_i,
    output logic                 in_ready_o,
    input  logic [WIDTH-1:0]     x1_real_i,
    input  logic [WIDTH-1:0]     x1_imag_i,
    input  logic [WIDTH-1:0]     x2_real_i,
    input  logic [WIDTH-1:0]     x2_imag_i,
    input  logic [TW_WIDTH-1:0]  w_real_i,
    input  logic [TW_WIDTH-1:0]  w_imag_i,
    input  logic                 inverse_i,
    input  logic                 scale_i,
    input  logic [TAG_WIDTH-1:0] tag_i,
    output logic                 out_valid_o,
    input  logic                 out_ready_i,
    output logic [WIDTH-1:0]     X1_real_o,
    output logic [WIDTH-1:0]     X1_imag_o,
    output logic [WIDTH-1:0]     X2_real_o,
    output logic [WIDTH-1:0]     X2_imag_o,
    output logic [TAG_WIDTH-1:0] tag_o,
    output logic [3:0]           ovf_o,
    input  logic                 clr_ovf_i,
    output logic [3:0]           ovf_sticky_o
);

    localparam int PW = WIDTH + TW_WIDTH + 2;
    localparam int SW = WIDTH + 3;
    localparam logic signed [PW-1:0] RND  = PW'(1) <<< (TW_FRAC - 1);
    localparam logic signed [SW-1:0] SMAX = SW'((1 << (WIDTH - 1)) - 1);
    localparam logic signed [SW-1:0] SMIN = ~SMAX;

    logic advance;
    assign advance    = !out_valid_o || out_ready_i;
    assign in_ready_o = advance;

    logic                        s1_valid, s1_inv, s1_scale;
    logic signed [WIDTH-1:0]     s1_x1r, s1_x1i, s1_x2r, s1_x2i;
    logic signed [TW_WIDTH-1:0]  s1_wr, s1_wi;
    logic [TAG_WIDTH-1:0]        s1_tag;

    logic                        s2_valid, s2_scale;
    logic signed [WIDTH-1:0]     s2_x1r, s2_x1i;
    logic signed [WIDTH+1:0]     s2_pr, s2_pi;
    logic [TAG_WIDTH-1:0]        s2_tag;

    // One extra bit so conjugating the most negative twiddle cannot wrap.
    logic signed [TW_WIDTH:0]    wi_ext, wi_eff;
    logic signed [PW-1:0]        full_r, full_i;

    assign wi_ext = {s1_wi[TW_WIDTH-1], s1_wi};
    assign wi_eff = s1_inv ? -wi_ext : wi_ext;
    assign full_r = PW'(s1_x2r) * PW'(s1_wr) - PW'(s1_x2i) * PW'(wi_eff);
    assign full_i = PW'(s1_x2r) * PW'(wi_eff) + PW'(s1_x2i) * PW'(s1_wr);

    function automatic logic [WIDTH:0] finish_comp(input logic signed [SW-1:0] sum,
                                                   input logic scale);
        logic signed [SW-1:0] v;
        v = scale ? (sum >>> 1) : sum;
        if (v > SMAX)
            return {1'b1, SMAX[WIDTH-1:0]};
        else if (v < SMIN)
            return {1'b1, SMIN[WIDTH-1:0]};
        else
            return {1'b0, v[WIDTH-1:0]};
    endfunction

    logic signed [SW-1:0] x1r_ext, x1i_ext, pr_ext, pi_ext;
    logic [WIDTH:0]       r1r, r1i, r2r, r2i;

    assign x1r_ext = SW'(s2_x1r);
    assign x1i_ext = SW'(s2_x1i);
    assign pr_ext  = SW'(s2_pr);
    assign pi_ext  = SW'(s2_pi);
    assign r1r = finish_comp(x1r_ext + pr_ext, s2_scale);
    assign r1i = finish_comp(x1i_ext + pi_ext, s2_scale);
    assign r2r = finish_comp(x1r_ext - pr_ext, s2_scale);
    assign r2i = finish_comp(x1i_ext - pi_ext, s2_scale);

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            s1_valid <= 1'b0;
            s1_inv   <= 1'b0;
            s1_scale <= 1'b0;
            s1_x1r   <= '0;
            s1_x1i   <= '0;
            s1_x2r   <= '0;
            s1_x2i   <= '0;
            s1_wr    <= '0;
            s1_wi    <= '0;
            s1_tag   <= '0;
            s2_valid <= 1'b0;
            s2_scale <= 1'b0;
            s2_x1r   <= '0;
            s2_x1i   <= '0;
            s2_pr    <= '0;
            s2_pi    <= '0;
            s2_tag   <= '0;
            out_valid_o <= 1'b0;
            X1_real_o   <= '0;
            X1_imag_o   <= '0;
            X2_real_o   <= '0;
            X2_imag_o   <= '0;
            tag_o       <= '0;
            ovf_o       <= '0;
        end else if (advance) begin
            s1_valid <= in_valid_i;
            s1_inv   <= inverse_i;
            s1_scale <= scale_i;
            s1_x1r   <= x1_real_i;
            s1_x1i   <= x1_imag_i;
            s1_x2r   <= x2_real_i;
            s1_x2i   <= x2_imag_i;
            s1_wr    <= w_real_i;
            s1_wi    <= w_imag_i;
            s1_tag   <= tag_i;
            s2_valid <= s1_valid;
            s2_scale <= s1_scale;
            s2_x1r   <= s1_x1r;
            s2_x1i   <= s1_x1i;
            s2_pr    <= (WIDTH+2)'((full_r + RND) >>> TW_FRAC);
            s2_pi    <= (WIDTH+2)'((full_i + RND) >>> TW_FRAC);
            s2_tag   <= s1_tag;
            out_valid_o <= s2_valid;
            X1_real_o   <= r1r[WIDTH-1:0];
            X1_imag_o   <= r1i[WIDTH-1:0];
            X2_real_o   <= r2r[WIDTH-1:0];
            X2_imag_o   <= r2i[WIDTH-1:0];
            tag_o       <= s2_tag;
            ovf_o       <= {r2i[WIDTH], r2r[WIDTH], r1i[WIDTH], r1r[WIDTH]};
        end
    end

    // A set arriving in the same cycle as a clear survives.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i)
            ovf_sticky_o <= '0;
        else
            ovf_sticky_o <= (clr_ovf_i ? 4'b0000 : ovf_sticky_o)
                          | ((out_valid_o && out_ready_i) ? ovf_o : 4'b0000);
    end

endmodule

// File: tb/tb_fft_butterfly_pipe.sv
// tb/tb_fft_butterfly_pipe.sv - directed self-checking bench for fft_butterfly_pipe
module tb_fft_butterfly_pipe;

    logic        clk_i = 1'b0;
    logic        rst_n_i;
    logic        in_valid_i, in_ready_o;
    logic [15:0] x1_real_i, x1_imag_i, x2_real_i, x2_imag_i;
    logic [15:0] w_real_i, w_imag_i;
    logic        inverse_i, scale_i;
    logic [7:0]  tag_i;
    logic        out_valid_o, out_ready_i;
    logic [15:0] X1_real_o, X1_imag_o, X2_real_o, X2_imag_o;
    logic [7:0]  tag_o;
    logic [3:0]  ovf_o;
    logic        clr_ovf_i;
    logic [3:0]  ovf_sticky_o;

    int checks = 0;
    int failures = 0;

    fft_butterfly_pipe dut (
        .clk_i(clk_i), .rst_n_i(rst_n_i),
        .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
        .x1_real_i(x1_real_i), .x1_imag_i(x1_imag_i),
        .x2_real_i(x2_real_i), .x2_imag_i(x2_imag_i),
        .w_real_i(w_real_i), .w_imag_i(w_imag_i),
        .inverse_i(inverse_i), .scale_i(scale_i), .tag_i(tag_i),
        .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
        .X1_real_o(X1_real_o), .X1_imag_o(X1_imag_o),
        .X2_real_o(X2_real_o), .X2_imag_o(X2_imag_o),
        .tag_o(tag_o), .ovf_o(ovf_o),
        .clr_ovf_i(clr_ovf_i), .ovf_sticky_o(ovf_sticky_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string nm, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", nm, obs, exp);
        end
    endtask

    // Called at a negedge; returns just after the acceptance edge.
    task automatic send(input int x1r, input int x1i, input int x2r, input int x2i,
                        input int wr, input int wi, input logic inv, input logic sc,
                        input logic [7:0] tag);
        x1_real_i = 16'(x1r); x1_imag_i = 16'(x1i);
        x2_real_i = 16'(x2r); x2_imag_i = 16'(x2i);
        w_real_i  = 16'(wr);  w_imag_i  = 16'(wi);
        inverse_i = inv; scale_i = sc; tag_i = tag;
        in_valid_i = 1'b1;
        @(posedge clk_i);
        #1 in_valid_i = 1'b0;
    endtask

    task automatic wait_out(input string nm);
        int lat;
        lat = 1;
        while (lat < 20) begin
            @(negedge clk_i);
            if (out_valid_o) break;
            @(posedge clk_i);
            lat++;
        end
        chk({nm, "_latency"}, lat, 3);
    endtask

    task automatic check_out(input string nm, input int x1r, input int x1i,
                             input int x2r, input int x2i, input logic [3:0] ovf,
                             input logic [7:0] tag);
        chk({nm, "_X1r"}, $signed(X1_real_o), x1r);
        chk({nm, "_X1i"}, $signed(X1_imag_o), x1i);
        chk({nm, "_X2r"}, $signed(X2_real_o), x2r);
        chk({nm, "_X2i"}, $signed(X2_imag_o), x2i);
        chk({nm, "_ovf"}, ovf_o, ovf);
        chk({nm, "_tag"}, tag_o, tag);
    endtask

    task automatic expect_beat(input string nm, input int x1r, input int x1i,
                               input int x2r, input int x2i, input logic [3:0] ovf,
                               input logic [7:0] tag);
        wait_out(nm);
        check_out(nm, x1r, x1i, x2r, x2i, ovf, tag);
        @(posedge clk_i);
        @(negedge clk_i);
    endtask

    initial begin
        int tx, rx, cyc, extra;
        logic hold;
        logic [7:0] h_tag;
        logic [15:0] h_x1r;

        rst_n_i = 1'b0; in_valid_i = 1'b0; out_ready_i = 1'b1; clr_ovf_i = 1'b0;
        x1_real_i = '0; x1_imag_i = '0; x2_real_i = '0; x2_imag_i = '0;
        w_real_i = '0; w_imag_i = '0; inverse_i = 1'b0; scale_i = 1'b0; tag_i = '0;
        #1;
        chk("rst_in_ready", in_ready_o, 1);
        chk("rst_out_valid", out_valid_o, 0);
        check_out("rst", 0, 0, 0, 0, 4'b0000, 8'h00);
        chk("rst_sticky", ovf_sticky_o, 0);
        @(posedge clk_i); @(posedge clk_i); @(negedge clk_i);
        rst_n_i = 1'b1;

        // Basic butterfly with w = 1.0, plus output stall holding
        send(1000, 0, 2000, 0, 16384, 0, 1'b0, 1'b0, 8'h5A);
        wait_out("basic");
        out_ready_i = 1'b0;
        #1 chk("stall_in_ready", in_ready_o, 0);
        @(posedge clk_i); @(negedge clk_i);
        chk("stall_valid", out_valid_o, 1);
        check_out("basic", 3000, 0, -1000, 0, 4'b0000, 8'h5A);
        out_ready_i = 1'b1;
        @(posedge clk_i); @(negedge clk_i);
        chk("basic_drained", out_valid_o, 0);

        send(0, 0, 100, 0, 0, -16384, 1'b0, 1'b0, 8'h01);
        expect_beat("fwd_j", 0, -100, 0, 100, 4'b0000, 8'h01);
        send(0, 0, 100, 0, 0, -16384, 1'b1, 1'b0, 8'h02);
        expect_beat("inv_j", 0, 100, 0, -100, 4'b0000, 8'h02);

        // Most negative twiddle imaginary conjugated gives +2.0
        send(0, 0, 0, 100, 0, -32768, 1'b1, 1'b0, 8'h03);
        expect_beat("tw_min", -200, 0, 200, 0, 4'b0000, 8'h03);

        send(30000, 0, 10000, 0, 16384, 0, 1'b0, 1'b0, 8'h04);
        expect_beat("sat_pos", 32767, 0, 20000, 0, 4'b0001, 8'h04);
        chk("sticky_set", ovf_sticky_o, 4'b0001);
        send(30000, 0, 10000, 0, 16384, 0, 1'b0, 1'b1, 8'h05);
        expect_beat("scaled", 20000, 0, 10000, 0, 4'b0000, 8'h05);
        chk("sticky_hold", ovf_sticky_o, 4'b0001);
        clr_ovf_i = 1'b1;
        @(posedge clk_i); @(negedge clk_i);
        clr_ovf_i = 1'b0;
        chk("sticky_clr", ovf_sticky_o, 4'b0000);

        send(-30000, 0, 10000, 0, 16384, 0, 1'b0, 1'b0, 8'h06);
        expect_beat("sat_neg", -20000, 0, -32768, 0, 4'b0100, 8'h06);
        chk("sticky_x2r", ovf_sticky_o, 4'b0100);

        send(0, 0, 3, 0, 8192, 0, 1'b0, 1'b0, 8'h07);
        expect_beat("rnd_pos", 2, 0, -2, 0, 4'b0000, 8'h07);
        send(0, 0, -3, 0, 8192, 0, 1'b0, 1'b0, 8'h08);
        expect_beat("rnd_neg", -1, 0, 1, 0, 4'b0000, 8'h08);

        // Randomised handshake stream: tags in order, outputs frozen while stalled
        tx = 0; rx = 0; cyc = 0; hold = 1'b0; h_tag = '0; h_x1r = '0;
        x1_imag_i = '0; x2_real_i = '0; x2_imag_i = '0;
        w_real_i = 16'd16384; w_imag_i = '0; inverse_i = 1'b0; scale_i = 1'b0;
        while (rx < 8 && cyc < 400) begin
            if (hold) begin
                chk("hold_valid", out_valid_o, 1);
                chk("hold_tag", tag_o, h_tag);
                chk("hold_x1r", $signed(X1_real_o), $signed(h_x1r));
            end
            out_ready_i = 1'($urandom_range(0, 1));
            in_valid_i  = (tx < 8) && ($urandom_range(0, 2) != 0);
            x1_real_i   = 16'(tx * 10);
            tag_i       = 8'(tx);
            #1;
            hold  = out_valid_o && !out_ready_i;
            h_tag = tag_o;
            h_x1r = X1_real_o;
            if (out_valid_o && out_ready_i) begin
                chk("stream_tag", tag_o, rx);
                chk("stream_x1r", $signed(X1_real_o), rx * 10);
                rx++;
            end
            if (in_valid_i && in_ready_o) tx++;
            @(posedge clk_i); @(negedge clk_i);
            cyc++;
        end
        in_valid_i = 1'b0; out_ready_i = 1'b1;
        chk("stream_count", rx, 8);
        extra = 0;
        repeat (5) begin
            if (out_valid_o) extra++;
            @(posedge clk_i); @(negedge clk_i);
        end
        chk("stream_no_dup", extra, 0);

        // Reset with three beats in flight
        x2_real_i = 16'd500; x1_imag_i = '0; x2_imag_i = '0;
        x1_real_i = 16'd1; tag_i = 8'h11; in_valid_i = 1'b1;
        @(posedge clk_i); #1 tag_i = 8'h22;
        @(posedge clk_i); #1 tag_i = 8'h33;
        @(posedge clk_i); #1 in_valid_i = 1'b0;
        @(negedge clk_i);
        chk("flight_valid", out_valid_o, 1);
        chk("flight_tag", tag_o, 8'h11);
        rst_n_i = 1'b0;
        #1;
        chk("mid_rst_valid", out_valid_o, 0);
        chk("mid_rst_in_ready", in_ready_o, 1);
        check_out("mid_rst", 0, 0, 0, 0, 4'b0000, 8'h00);
        chk("mid_rst_sticky", ovf_sticky_o, 0);
        @(posedge clk_i); @(posedge clk_i); @(negedge clk_i);
        rst_n_i = 1'b1;
        extra = 0;
        repeat (6) begin
            if (out_valid_o) extra++;
            @(posedge clk_i); @(negedge clk_i);
        end
        chk("post_rst_quiet", extra, 0);
        send(1000, 0, 2000, 0, 16384, 0, 1'b0, 1'b0, 8'h5A);
        expect_beat("post_rst", 3000, 0, -1000, 0, 4'b0000, 8'h5A);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
